// File: rtl/enemy_walker_if.sv
// Interface: enemy_walker_if
// Purpose : Bundles the per-enemy control inputs (frame tick, tile collision
//           flags, stomp, respawn) with the packed state and dead flag the
//           walker publishes to the renderer/collision bus.
// Signals :
//   tick     1   frame step enable
//   col      4   collision flags {bottom, right, top, left}
//   stomp    1   player landed on the enemy
//   respawn  1   revive request, only honoured while DEAD
//   state_o  32  {xPos, yPos, xSpdEff, ySpeed, xDir, alive}
//   dead     1   enemy is in the DEAD state
// Modports:
//   master  drives the inputs and observes the state (game logic / bench)
//   slave   the enemy_walker itself
interface enemy_walker_if;
   logic        tick;
   logic [3:0]  col;
   logic        stomp;
   logic        respawn;
   logic [31:0] state_o;
   logic        dead;

   modport master (
      output tick, col, stomp, respawn,
      input  state_o, dead
   );

   modport slave (
      input  tick, col, stomp, respawn,
      output state_o, dead
   );
endinterface

// File: rtl/enemy_walker.sv
// Module : enemy_walker
// Purpose: One patrolling enemy. It walks horizontally and bounces off walls by
//          snapping to the tile edge. It falls under gravity when it has no
//          floor, and it dies after a delay when stomped or at once when it
//          falls out of the world. From DEAD it can be respawned.
// Ports  :
//   sim_clk  in   clock
//   reset    in   synchronous, active-high; restores spawn values
//   bus      slave modport of enemy_walker_if (tick/col/stomp/respawn in,
//            state_o/dead out)
module enemy_walker #(
   parameter int X_INIT    = 200,
   parameter int Y_INIT    = 150,
   parameter int X_SPEED   = 3,
   parameter int DIR_INIT  = 1,
   parameter int GRAV      = 1,
   parameter int MAX_FALL  = 8,
   parameter int TILE_LOG2 = 5,
   parameter int DIE_TICKS = 30,
   parameter int Y_LIMIT   = 480
) (
   input logic           sim_clk,
   input logic           reset,
   enemy_walker_if.slave bus
);

   typedef enum logic [1:0] {WALK, FALL, DYING, DEAD} walkState_t;

   localparam int CNT_W = (DIE_TICKS > 1) ? $clog2(DIE_TICKS) : 1;

   localparam logic [9:0]       X_START   = 10'(X_INIT);
   localparam logic [9:0]       Y_START   = 10'(Y_INIT);
   localparam logic [9:0]       X_STEP    = 10'(X_SPEED);
   localparam logic [4:0]       X_SPD5    = 5'(X_SPEED);
   localparam logic             DIR_START = 1'(DIR_INIT);
   localparam logic [5:0]       GRAV6     = 6'(GRAV);
   localparam logic [4:0]       GRAV5     = 5'(GRAV);
   localparam logic [5:0]       MAX_FALL6 = 6'(MAX_FALL);
   localparam logic [9:0]       TILE      = 10'(1 << TILE_LOG2);
   localparam logic [9:0]       TILE_MASK = TILE - 10'd1;
   localparam logic [10:0]      Y_LIM11   = 11'(Y_LIMIT);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIE_TICKS - 1);

   walkState_t       state;
   logic [9:0]       xPos;
   logic [9:0]       yPos;
   logic [4:0]       ySpeed;
   logic             xDir;
   logic [CNT_W-1:0] cnt;

   logic [9:0]  nextX;
   logic [9:0]  snapX;
   logic        wallHit;
   logic [10:0] fallSum;
   logic        outOfWorld;
   logic [5:0]  accelSpeed;
   logic [4:0]  fallSpeed;
   logic        alive;

   // Candidate horizontal step and its wall-snapped version. A right-wall hit
   // parks the enemy on the last pixel of the tile before the wall. A left-wall
   // hit parks it on the first pixel of the next tile. When both flags are
   // set, the right wall takes precedence.
   always_comb begin
      nextX   = xDir ? (xPos + X_STEP) : (xPos - X_STEP);
      snapX   = nextX;
      wallHit = bus.col[2] | bus.col[0];
      if (bus.col[2]) begin
         snapX = nextX - (nextX & TILE_MASK) - 10'd1;
      end else if (bus.col[0]) begin
         snapX = nextX + (TILE - (nextX & TILE_MASK));
      end
   end

   // The falling-speed update saturates at MAX_FALL. The out-of-world test uses
   // 11 bits so that a position near the top of the 10-bit range does not wrap
   // back into the world.
   always_comb begin
      fallSum    = {1'b0, yPos} + {6'd0, ySpeed};
      outOfWorld = (fallSum >= Y_LIM11);
      accelSpeed = {1'b0, ySpeed} + GRAV6;
      fallSpeed  = (accelSpeed > MAX_FALL6) ? MAX_FALL6[4:0] : accelSpeed[4:0];
   end

   // Main state machine. Reset and respawn-from-DEAD act on any cycle. All
   // other motion and timers advance only on tick. Within a live tick, stomp
   // beats falling out of the world, which beats normal motion. In normal
   // motion, vertical and horizontal updates both happen in the same tick.
   always_ff @(posedge sim_clk) begin
      if (reset) begin
         state  <= WALK;
         xPos   <= X_START;
         yPos   <= Y_START;
         xDir   <= DIR_START;
         ySpeed <= 5'd0;
         cnt    <= '0;
      end else begin
         case (state)
            DEAD: begin
               if (bus.respawn) begin
                  state  <= WALK;
                  xPos   <= X_START;
                  yPos   <= Y_START;
                  xDir   <= DIR_START;
                  ySpeed <= 5'd0;
                  cnt    <= '0;
               end
            end
            DYING: begin
               if (bus.tick) begin
                  if (cnt == '0) begin
                     state <= DEAD;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            default: begin
               if (bus.tick) begin
                  if (bus.stomp) begin
                     state  <= DYING;
                     cnt    <= CNT_START;
                     ySpeed <= 5'd0;
                  end else if ((state == FALL) && outOfWorld) begin
                     state <= DEAD;
                  end else begin
                     if (state == WALK) begin
                        if (!bus.col[3]) begin
                           state  <= FALL;
                           ySpeed <= GRAV5;
                        end
                     end else if (!bus.col[3]) begin
                        yPos   <= yPos + {5'd0, ySpeed};
                        ySpeed <= fallSpeed;
                     end else begin
                        yPos   <= yPos & ~TILE_MASK;
                        ySpeed <= 5'd0;
                        state  <= WALK;
                     end
                     xPos <= snapX;
                     if (wallHit) begin
                        xDir <= ~xDir;
                     end
                  end
               end
            end
         endcase
      end
   end

   // The published state is taken only from registers, so it changes on the
   // cycle after the sampling edge.
   always_comb begin
      alive       = (state == WALK) || (state == FALL);
      bus.state_o = {xPos, yPos, (alive ? X_SPD5 : 5'd0), ySpeed, xDir, alive};
      bus.dead    = (state == DEAD);
   end

endmodule

// File: tb/tb_enemy_walker.sv
// Testbench: tb_enemy_walker
// Purpose  : Drives the enemy walker through walking, wall bounces, falling and
//            landing, stomp death, long falls out of the world, respawn and
//            reset. Each applied vector pushes the expected state, produced by
//            a small behavioural model, onto a scoreboard. Each test task pops
//            that entry and compares it after the clock edge. Values quoted
//            directly from the behaviour description are also compared as
//            fixed constants.
module tb_enemy_walker;

   typedef struct {
      logic [31:0] st;
      logic        dead;
   } expect_t;

   logic simClk = 1'b0;
   logic reset  = 1'b1;

   enemy_walker_if bus ();

   enemy_walker dut (
      .sim_clk (simClk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 simClk = ~simClk;

   expect_t sbQ[$];
   expect_t exp;
   int      vectors     = 0;
   int      miscompares = 0;

   // Behavioural model: 0=walk 1=fall 2=dying 3=dead
   int mX, mY, mYs, mDir, mCnt, mSt;

   task automatic modelSpawn();
      mX = 200; mY = 150; mYs = 0; mDir = 1; mCnt = 0; mSt = 0;
   endtask

   task automatic modelStep(input bit rst, input bit tk, input bit [3:0] c,
                            input bit st, input bit rs);
      int nx;
      if (rst) modelSpawn();
      else if (mSt == 3) begin
         if (rs) modelSpawn();
      end else if (tk) begin
         if (mSt == 2) begin
            if (mCnt == 0) mSt = 3;
            else mCnt = mCnt - 1;
         end else if (st) begin
            mSt = 2; mCnt = 29; mYs = 0;
         end else if (mSt == 1 && (mY + mYs) >= 480) begin
            mSt = 3;
         end else begin
            if (mSt == 0) begin
               if (!c[3]) begin mSt = 1; mYs = 1; end
            end else if (!c[3]) begin
               mY  = (mY + mYs) % 1024;
               mYs = (mYs + 1 > 8) ? 8 : mYs + 1;
            end else begin
               mY = mY - (mY % 32); mYs = 0; mSt = 0;
            end
            nx = mDir ? (mX + 3) % 1024 : (mX + 1024 - 3) % 1024;
            if (c[2]) begin
               mX = (nx - (nx % 32) - 1 + 1024) % 1024; mDir = 1 - mDir;
            end else if (c[0]) begin
               mX = (nx + 32 - (nx % 32)) % 1024; mDir = 1 - mDir;
            end else mX = nx;
         end
      end
   endtask

   function automatic expect_t modelExpect();
      expect_t e;
      bit alv;
      alv    = (mSt < 2);
      e.st   = {10'(mX), 10'(mY), (alv ? 5'd3 : 5'd0), 5'(mYs), 1'(mDir), alv};
      e.dead = (mSt == 3);
      return e;
   endfunction

   // Drive one cycle of inputs away from the active edge, record the expected
   // outcome, then step to just after the edge where the result is visible.
   task automatic applyStimulus(input bit rst, input bit tk, input bit [3:0] c,
                                input bit st, input bit rs);
      @(negedge simClk);
      reset       = rst;
      bus.tick    = tk;
      bus.col     = c;
      bus.stomp   = st;
      bus.respawn = rs;
      modelStep(rst, tk, c, st, rs);
      sbQ.push_back(modelExpect());
      @(posedge simClk);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1, 0, 4'b0000, 0, 0);
      exp = sbQ.pop_front(); vectors++;
      if (bus.state_o !== exp.st || bus.dead !== exp.dead) begin
         miscompares++;
         $display("[TB] FAIL reset_sb: got %h/%b want %h/%b", bus.state_o, bus.dead, exp.st, exp.dead);
      end
      vectors++;
      if (bus.state_o !== {10'd200, 10'd150, 5'd3, 5'd0, 1'b1, 1'b1} || bus.dead !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_spawn: got %h/%b want %h/0", bus.state_o, bus.dead,
                  {10'd200, 10'd150, 5'd3, 5'd0, 1'b1, 1'b1});
      end
   endtask

   task automatic test_walk();
      applyStimulus(1, 0, 4'b0000, 0, 0);
      void'(sbQ.pop_front());
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 4'b1000, 0, 0);
         exp = sbQ.pop_front(); vectors++;
         if (bus.state_o !== exp.st || bus.dead !== exp.dead) begin
            miscompares++;
            $display("[TB] FAIL walk_%0d: got %h/%b want %h/%b", i, bus.state_o, bus.dead, exp.st, exp.dead);
         end
      end
      vectors++;
      if (bus.state_o[31:22] !== 10'd209 || bus.state_o[21:12] !== 10'd150 || bus.state_o[0] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL walk_const: got x=%0d y=%0d alive=%b want 209/150/1",
                  bus.state_o[31:22], bus.state_o[21:12], bus.state_o[0]);
      end
   endtask

   task automatic test_collision();
      applyStimulus(1, 0, 4'b0000, 0, 0);
      void'(sbQ.pop_front());
      applyStimulus(0, 1, 4'b1100, 0, 0);
      exp = sbQ.pop_front(); vectors++;
      if (bus.state_o !== exp.st) begin
         miscompares++;
         $display("[TB] FAIL right_wall_sb: got %h want %h", bus.state_o, exp.st);
      end
      vectors++;
      if (bus.state_o[31:22] !== 10'd191 || bus.state_o[1] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL right_wall: got x=%0d dir=%b want 191/0", bus.state_o[31:22], bus.state_o[1]);
      end
      applyStimulus(0, 1, 4'b1001, 0, 0);
      exp = sbQ.pop_front(); vectors++;
      if (bus.state_o !== exp.st) begin
         miscompares++;
         $display("[TB] FAIL left_wall_sb: got %h want %h", bus.state_o, exp.st);
      end
      vectors++;
      if (bus.state_o[31:22] !== 10'd192 || bus.state_o[1] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL left_wall: got x=%0d dir=%b want 192/1", bus.state_o[31:22], bus.state_o[1]);
      end
   endtask

   task automatic test_fall();
      int yWant[4]  = '{150, 151, 153, 156};
      int ysWant[4] = '{1, 2, 3, 4};
      applyStimulus(1, 0, 4'b0000, 0, 0);
      void'(sbQ.pop_front());
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 4'b0000, 0, 0);
         exp = sbQ.pop_front(); vectors++;
         if (bus.state_o !== exp.st || bus.dead !== exp.dead) begin
            miscompares++;
            $display("[TB] FAIL fall_sb_%0d: got %h/%b want %h/%b", i, bus.state_o, bus.dead, exp.st, exp.dead);
         end
         vectors++;
         if (bus.state_o[21:12] !== 10'(yWant[i]) || bus.state_o[6:2] !== 5'(ysWant[i])) begin
            miscompares++;
            $display("[TB] FAIL fall_%0d: got y=%0d ys=%0d want %0d/%0d", i,
                     bus.state_o[21:12], bus.state_o[6:2], yWant[i], ysWant[i]);
         end
         // a tick-free cycle must hold everything
         applyStimulus(0, 0, 4'b0101, 1, 1);
         exp = sbQ.pop_front(); vectors++;
         if (bus.state_o !== exp.st || bus.dead !== exp.dead) begin
            miscompares++;
            $display("[TB] FAIL fall_hold_%0d: got %h/%b want %h/%b", i, bus.state_o, bus.dead, exp.st, exp.dead);
         end
      end
      applyStimulus(0, 1, 4'b1000, 0, 0);
      exp = sbQ.pop_front(); vectors++;
      if (bus.state_o !== exp.st || bus.state_o[21:12] !== 10'd128 || bus.state_o[6:2] !== 5'd0) begin
         miscompares++;
         $display("[TB] FAIL land: got %h want %h (y=128 ys=0)", bus.state_o, exp.st);
      end
   endtask

   task automatic test_stomp();
      applyStimulus(1, 0, 4'b0000, 0, 0);
      void'(sbQ.pop_front());
      applyStimulus(0, 1, 4'b1000, 1, 0);
      exp = sbQ.pop_front(); vectors++;
      if (bus.state_o !== exp.st || bus.state_o[0] !== 1'b0 || bus.state_o[11:7] !== 5'd0) begin
         miscompares++;
         $display("[TB] FAIL stomp: got %h want %h", bus.state_o, exp.st);
      end
      for (int i = 0; i < 30; i++) begin
         if (i % 7 == 3) begin
            applyStimulus(0, 0, 4'($urandom_range(0, 15)), 1, 0);
            void'(sbQ.pop_front());
         end
         applyStimulus(0, 1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
         exp = sbQ.pop_front(); vectors++;
         if (bus.state_o !== exp.st || bus.dead !== exp.dead) begin
            miscompares++;
            $display("[TB] FAIL dying_%0d: got %h/%b want %h/%b", i, bus.state_o, bus.dead, exp.st, exp.dead);
         end
      end
      vectors++;
      if (bus.dead !== 1'b1 || bus.state_o[31:12] !== {10'd200, 10'd150}) begin
         miscompares++;
         $display("[TB] FAIL dead_after_30: got dead=%b pos=%h want 1/%h", bus.dead, bus.state_o[31:12],
                  {10'd200, 10'd150});
      end
      applyStimulus(0, 0, 4'b0000, 1, 1);
      exp = sbQ.pop_front(); vectors++;
      if (bus.state_o !== {10'd200, 10'd150, 5'd3, 5'd0, 1'b1, 1'b1} || bus.dead !== exp.dead) begin
         miscompares++;
         $display("[TB] FAIL respawn: got %h/%b want %h/%b", bus.state_o, bus.dead, exp.st, exp.dead);
      end
   endtask

   task automatic test_long_fall();
      int budget = 0;
      applyStimulus(1, 0, 4'b0000, 0, 0);
      void'(sbQ.pop_front());
      while (mSt != 3 && budget < 100) begin
         applyStimulus(0, 1, 4'b0000, 0, 0);
         budget++;
         exp = sbQ.pop_front(); vectors++;
         if (bus.state_o !== exp.st || bus.dead !== exp.dead) begin
            miscompares++;
            $display("[TB] FAIL long_fall_%0d: got %h/%b want %h/%b", budget, bus.state_o, bus.dead, exp.st, exp.dead);
         end
      end
      vectors++;
      if (bus.dead !== 1'b1 || bus.state_o[21:12] !== 10'd474 || bus.state_o[6:2] !== 5'd8) begin
         miscompares++;
         $display("[TB] FAIL out_of_world: got dead=%b y=%0d ys=%0d want 1/474/8",
                  bus.dead, bus.state_o[21:12], bus.state_o[6:2]);
      end
      // DEAD ignores tick and stomp without respawn
      applyStimulus(0, 1, 4'b0000, 1, 0);
      exp = sbQ.pop_front(); vectors++;
      if (bus.state_o !== exp.st || bus.dead !== exp.dead) begin
         miscompares++;
         $display("[TB] FAIL dead_hold: got %h/%b want %h/%b", bus.state_o, bus.dead, exp.st, exp.dead);
      end
   endtask

   task automatic test_reset_mid_dying();
      applyStimulus(1, 0, 4'b0000, 0, 0);
      void'(sbQ.pop_front());
      applyStimulus(0, 1, 4'b0000, 1, 0);
      void'(sbQ.pop_front());
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 4'b1000, 0, 0);
         void'(sbQ.pop_front());
      end
      applyStimulus(1, 1, 4'b0000, 1, 0);
      exp = sbQ.pop_front(); vectors++;
      if (bus.state_o !== exp.st || bus.state_o !== {10'd200, 10'd150, 5'd3, 5'd0, 1'b1, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL reset_dying: got %h want %h", bus.state_o, exp.st);
      end
      // the dying counter must have been cleared: a fresh stomp needs all 30 ticks
      applyStimulus(0, 1, 4'b1000, 1, 0);
      void'(sbQ.pop_front());
      for (int i = 0; i < 29; i++) begin
         applyStimulus(0, 1, 4'b1000, 0, 0);
         void'(sbQ.pop_front());
      end
      vectors++;
      if (bus.dead !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL restomp_early: got dead=%b want 0", bus.dead);
      end
   endtask

   task automatic test_back_to_back();
      bit [3:0] c;
      applyStimulus(1, 0, 4'b0000, 0, 0);
      void'(sbQ.pop_front());
      for (int i = 0; i < 400; i++) begin
         c    = 4'($urandom_range(0, 15));
         c[3] = ($urandom_range(0, 3) != 0);
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, c,
                       $urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0);
         exp = sbQ.pop_front(); vectors++;
         if (bus.state_o !== exp.st || bus.dead !== exp.dead) begin
            miscompares++;
            $display("[TB] FAIL random_%0d: got %h/%b want %h/%b", i, bus.state_o, bus.dead, exp.st, exp.dead);
         end
      end
   endtask

   initial begin
      bus.tick    = 1'b0;
      bus.col     = 4'b0000;
      bus.stomp   = 1'b0;
      bus.respawn = 1'b0;
      modelSpawn();
      test_reset();
      test_walk();
      test_collision();
      test_fall();
      test_stomp();
      test_long_fall();
      test_reset_mid_dying();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
